// File: rtl/ddr_sched_pkg.sv
// Shared definitions for the DDR ring-buffer burst scheduler: FSM encoding,
// controller command codes and ring pointer helpers.
package ddr_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_BUSY = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_BUSY = 3'd4,
    ST_FLUSH   = 3'd5
  } sched_state_e;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  localparam int unsigned LEN_W  = 8;
  localparam int unsigned FILL_W = 32;

  // Bursts never straddle the ring end, so landing exactly on depth wraps to 0.
  function automatic logic [FILL_W-1:0] ptr_advance(input logic [FILL_W-1:0] ptr,
                                                    input int unsigned       step,
                                                    input int unsigned       depth);
    logic [FILL_W-1:0] nxt;
    nxt = ptr + FILL_W'(step);
    return (nxt >= FILL_W'(depth)) ? '0 : nxt;
  endfunction

endpackage

// File: rtl/ddr_ring_ptr.sv
// Ring bookkeeping: write/read beat pointers, fill level and full/empty flags
// expressed in whole bursts.
module ddr_ring_ptr
  import ddr_sched_pkg::*;
#(
  parameter int unsigned BURST_LEN  = 32,
  parameter int unsigned RING_DEPTH = 32'h0100_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_commit_i,
  input  logic              rd_commit_i,
  input  logic              flush_i,
  output logic [FILL_W-1:0] wr_ptr_o,
  output logic [FILL_W-1:0] rd_ptr_o,
  output logic [FILL_W-1:0] fill_o,
  output logic              full_c,
  output logic              empty_c
);

  localparam logic [FILL_W-1:0] BURST_BEATS = FILL_W'(BURST_LEN);
  localparam logic [FILL_W-1:0] ROOM_LIMIT  = FILL_W'(RING_DEPTH - BURST_LEN);

  logic [FILL_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0] fill_q, fill_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
      fill_d   = '0;
    end else begin
      if (wr_commit_i) begin
        wr_ptr_d = ptr_advance(wr_ptr_q, BURST_LEN, RING_DEPTH);
      end
      if (rd_commit_i) begin
        rd_ptr_d = ptr_advance(rd_ptr_q, BURST_LEN, RING_DEPTH);
      end
      fill_d = fill_q + (wr_commit_i ? BURST_BEATS : '0) - (rd_commit_i ? BURST_BEATS : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign fill_o   = fill_q;
  // Full means no room for another whole burst; empty means less than one burst stored.
  assign full_c   = (fill_q > ROOM_LIMIT);
  assign empty_c  = (fill_q < BURST_BEATS);

endmodule

// File: rtl/ddr_ring_sched.sv
// Burst scheduler turning DDR into a ring FIFO: drains the input FIFO in write
// bursts, refills the output FIFO in read bursts, one request in flight at a time.
module ddr_ring_sched
  import ddr_sched_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 30,
  parameter int unsigned BURST_LEN  = 32,
  parameter int unsigned RING_DEPTH = 32'h0100_0000,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned ADDR_STEP  = 8,
  parameter int unsigned DATA_BITS  = 256,
  parameter int unsigned CNT_WIDTH  = 12
) (
  input  logic                  ddr_clk_i,
  input  logic                  ddr_rst_n_i,
  input  logic                  init_done_i,
  input  logic                  flush_i,
  input  logic [CNT_WIDTH-1:0]  in_fifo_cnt_i,
  input  logic [DATA_BITS-1:0]  in_fifo_dout_i,
  output logic                  in_fifo_rd_o,
  input  logic                  in_fifo_full_i,
  input  logic [CNT_WIDTH-1:0]  out_fifo_free_i,
  output logic                  out_fifo_wr_o,
  output logic [DATA_BITS-1:0]  out_fifo_din_o,
  output logic                  wr_ddr_req_o,
  output logic [LEN_W-1:0]      wr_ddr_len_o,
  output logic [ADDR_WIDTH-1:0] wr_ddr_addr_o,
  input  logic                  wr_ddr_data_req_i,
  output logic [DATA_BITS-1:0]  wr_ddr_data_o,
  input  logic                  wr_ddr_finish_i,
  output logic                  rd_ddr_req_o,
  output logic [LEN_W-1:0]      rd_ddr_len_o,
  output logic [ADDR_WIDTH-1:0] rd_ddr_addr_o,
  input  logic                  rd_ddr_data_valid_i,
  input  logic [DATA_BITS-1:0]  rd_ddr_data_i,
  input  logic                  rd_ddr_finish_i,
  input  logic                  burst_idle_i,
  output logic [FILL_W-1:0]     ring_fill_o,
  output logic [31:0]           overflow_cnt_o,
  output logic                  sched_idle_o
);

  localparam logic [LEN_W-1:0]  BURST_LEN_V = LEN_W'(BURST_LEN);
  localparam logic [FILL_W-1:0] BURST_CMP   = FILL_W'(BURST_LEN);

  sched_state_e state_q, state_d;
  logic                  last_wr_q, last_wr_d;
  logic                  wr_req_q, wr_req_d;
  logic                  rd_req_q, rd_req_d;
  logic [LEN_W-1:0]      wr_len_q, wr_len_d;
  logic [LEN_W-1:0]      rd_len_q, rd_len_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [31:0]           ovf_q, ovf_d;
  logic                  idle_q, idle_d;

  logic                  wr_commit, rd_commit, ring_flush;
  logic [FILL_W-1:0]     wr_ptr, rd_ptr, fill;
  logic                  ring_full, ring_empty;
  logic                  wr_ok, rd_ok;

  function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [FILL_W-1:0] ptr);
    return ADDR_WIDTH'(64'(BASE_ADDR) + 64'(ptr) * 64'(ADDR_STEP));
  endfunction

  ddr_ring_ptr #(
    .BURST_LEN  (BURST_LEN),
    .RING_DEPTH (RING_DEPTH)
  ) u_ring_ptr (
    .clk         (ddr_clk_i),
    .rst_n       (ddr_rst_n_i),
    .wr_commit_i (wr_commit),
    .rd_commit_i (rd_commit),
    .flush_i     (ring_flush),
    .wr_ptr_o    (wr_ptr),
    .rd_ptr_o    (rd_ptr),
    .fill_o      (fill),
    .full_c      (ring_full),
    .empty_c     (ring_empty)
  );

  assign wr_ok = (FILL_W'(in_fifo_cnt_i) >= BURST_CMP) && !ring_full;
  assign rd_ok = (FILL_W'(out_fifo_free_i) >= BURST_CMP) && !ring_empty;

  // Next-state, request launch and commit strobes.
  always_comb begin
    state_d    = state_q;
    last_wr_d  = last_wr_q;
    wr_req_d   = 1'b0;
    rd_req_d   = 1'b0;
    wr_len_d   = wr_len_q;
    rd_len_d   = rd_len_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    wr_commit  = 1'b0;
    rd_commit  = 1'b0;
    ring_flush = 1'b0;
    ovf_d      = ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (init_done_i && burst_idle_i) begin
          if (flush_i) begin
            state_d = ST_FLUSH;
          end else if (wr_ok && (!rd_ok || !last_wr_q)) begin
            state_d   = ST_WR_REQ;
            last_wr_d = 1'b1;
            wr_req_d  = 1'b1;
            wr_len_d  = BURST_LEN_V;
            wr_addr_d = addr_of(wr_ptr);
          end else if (rd_ok) begin
            state_d   = ST_RD_REQ;
            last_wr_d = 1'b0;
            rd_req_d  = 1'b1;
            rd_len_d  = BURST_LEN_V;
            rd_addr_d = addr_of(rd_ptr);
          end
        end
      end
      ST_WR_REQ: state_d = ST_WR_BUSY;
      ST_RD_REQ: state_d = ST_RD_BUSY;
      // Calibration loss abandons the burst; it is reissued from the same pointer.
      ST_WR_BUSY: begin
        if (!init_done_i) begin
          state_d = ST_IDLE;
        end else if (wr_ddr_finish_i) begin
          wr_commit = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_RD_BUSY: begin
        if (!init_done_i) begin
          state_d = ST_IDLE;
        end else if (rd_ddr_finish_i) begin
          rd_commit = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        ring_flush = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (in_fifo_full_i && ring_full && (ovf_q != 32'hFFFF_FFFF)) begin
      ovf_d = ovf_q + 32'd1;
    end
    idle_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
    if (!ddr_rst_n_i) begin
      state_q   <= ST_IDLE;
      last_wr_q <= 1'b0;
      wr_req_q  <= 1'b0;
      rd_req_q  <= 1'b0;
      wr_len_q  <= '0;
      rd_len_q  <= '0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      ovf_q     <= '0;
      idle_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      wr_req_q  <= wr_req_d;
      rd_req_q  <= rd_req_d;
      wr_len_q  <= wr_len_d;
      rd_len_q  <= rd_len_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      ovf_q     <= ovf_d;
      idle_q    <= idle_d;
    end
  end

  assign wr_ddr_req_o   = wr_req_q;
  assign wr_ddr_len_o   = wr_len_q;
  assign wr_ddr_addr_o  = wr_addr_q;
  assign rd_ddr_req_o   = rd_req_q;
  assign rd_ddr_len_o   = rd_len_q;
  assign rd_ddr_addr_o  = rd_addr_q;
  assign ring_fill_o    = fill;
  assign overflow_cnt_o = ovf_q;
  assign sched_idle_o   = idle_q;

  // Beat data flows straight between the FIFOs and the controller.
  assign in_fifo_rd_o   = wr_ddr_data_req_i;
  assign wr_ddr_data_o  = in_fifo_dout_i;
  assign out_fifo_wr_o  = rd_ddr_data_valid_i;
  assign out_fifo_din_o = rd_ddr_data_i;

endmodule

// File: tb/tb_ddr_ring_sched.sv
// Scoreboard bench for ddr_ring_sched: directed scenarios with a model DDR
// controller; expected requests are queued and checked by a monitor.
module tb_ddr_ring_sched;

  localparam int unsigned AW = 30;
  localparam int unsigned BL = 32;
  localparam int unsigned DB = 32;
  localparam int unsigned CW = 12;

  logic          clk, rst_n;
  logic          init_done, flush, in_full, burst_idle;
  logic [CW-1:0] in_cnt, out_free;
  logic [DB-1:0] in_dout, rd_data;
  logic          wr_data_req, wr_finish, rd_valid, rd_finish;
  logic          in_rd, out_wr, wr_req, rd_req, sched_idle;
  logic [DB-1:0] out_din, wr_data;
  logic [7:0]    wr_len, rd_len;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [31:0]   ring_fill, ovf_cnt;

  ddr_ring_sched #(
    .ADDR_WIDTH (AW), .BURST_LEN (BL), .RING_DEPTH (64), .BASE_ADDR (0),
    .ADDR_STEP (8), .DATA_BITS (DB), .CNT_WIDTH (CW)
  ) dut (
    .ddr_clk_i (clk), .ddr_rst_n_i (rst_n), .init_done_i (init_done), .flush_i (flush),
    .in_fifo_cnt_i (in_cnt), .in_fifo_dout_i (in_dout), .in_fifo_rd_o (in_rd),
    .in_fifo_full_i (in_full), .out_fifo_free_i (out_free), .out_fifo_wr_o (out_wr),
    .out_fifo_din_o (out_din), .wr_ddr_req_o (wr_req), .wr_ddr_len_o (wr_len),
    .wr_ddr_addr_o (wr_addr), .wr_ddr_data_req_i (wr_data_req), .wr_ddr_data_o (wr_data),
    .wr_ddr_finish_i (wr_finish), .rd_ddr_req_o (rd_req), .rd_ddr_len_o (rd_len),
    .rd_ddr_addr_o (rd_addr), .rd_ddr_data_valid_i (rd_valid), .rd_ddr_data_i (rd_data),
    .rd_ddr_finish_i (rd_finish), .burst_idle_i (burst_idle), .ring_fill_o (ring_fill),
    .overflow_cnt_o (ovf_cnt), .sched_idle_o (sched_idle)
  );

  typedef struct { bit is_wr; int unsigned addr; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int req_seen = 0;
  int rd_pulses = 0;
  bit ctrl_en = 1'b1;
  bit ctrl_busy = 1'b0;
  bit prev_req = 1'b0;
  exp_t mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit is_wr, input int unsigned addr);
    exp_t e;
    e.is_wr = is_wr;
    e.addr  = addr;
    exp_q.push_back(e);
  endtask

  task automatic wait_reqs(input int target);
    int n = 0;
    while (req_seen < target && n < 2000) begin
      tick();
      n++;
    end
    if (req_seen < target) check("timeout_req", 64'(req_seen), 64'(target));
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((ctrl_busy || !sched_idle || exp_q.size() != 0) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) check("timeout_quiet", 64'(exp_q.size()), 64'd0);
    repeat (3) tick();
  endtask

  // Monitor: every request pulse is matched against the scoreboard queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_rd) rd_pulses++;
      if (wr_req || rd_req) begin
        check("req_single_cycle", 64'(prev_req), 64'd0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_req: got wr=%0d rd=%0d wa=%0d ra=%0d expected none (t=%0t)",
                   wr_req, rd_req, wr_addr, rd_addr, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("req_type_wr", 64'(wr_req), 64'(mon_e.is_wr));
          check("req_type_rd", 64'(rd_req), 64'(!mon_e.is_wr));
          check("req_addr", 64'(mon_e.is_wr ? wr_addr : rd_addr), 64'(mon_e.addr));
          check("req_len", 64'(mon_e.is_wr ? wr_len : rd_len), 64'(BL));
        end
        req_seen++;
      end
      prev_req = wr_req || rd_req;
    end
  end

  // Model DDR controller: BL data beats, then a one-cycle finish.
  initial begin
    bit is_wr;
    wr_data_req = 1'b0; rd_valid = 1'b0; wr_finish = 1'b0; rd_finish = 1'b0;
    in_dout = '0; rd_data = '0; burst_idle = 1'b1;
    forever begin
      tick();
      if (ctrl_en && rst_n && (wr_req || rd_req)) begin
        is_wr = wr_req;
        ctrl_busy = 1'b1;
        burst_idle = 1'b0;
        for (int b = 0; b < int'(BL); b++) begin
          if (is_wr) begin
            wr_data_req = 1'b1;
            in_dout = 32'hA000_0000 + 32'(b);
          end else begin
            rd_valid = 1'b1;
            rd_data = 32'h5000_0000 + 32'(b);
          end
          if (b == 5) begin
            @(negedge clk);
            if (is_wr) begin
              check("wr_data_pass", 64'(wr_data), 64'h0000_0000_A000_0005);
            end else begin
              check("out_din_pass", 64'(out_din), 64'h0000_0000_5000_0005);
              check("out_wr_pass", 64'(out_wr), 64'd1);
            end
          end
          tick();
        end
        wr_data_req = 1'b0;
        rd_valid = 1'b0;
        if (is_wr) wr_finish = 1'b1; else rd_finish = 1'b1;
        tick();
        wr_finish = 1'b0;
        rd_finish = 1'b0;
        burst_idle = 1'b1;
        ctrl_busy = 1'b0;
      end
    end
  end

  initial begin
    rst_n = 1'b0; init_done = 1'b0; flush = 1'b0; in_full = 1'b0;
    in_cnt = '0; out_free = '0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_idle", 64'(sched_idle), 64'd1);
    check("rst_fill", 64'(ring_fill), 64'd0);
    check("rst_wr_req", 64'(wr_req), 64'd0);
    check("rst_rd_req", 64'(rd_req), 64'd0);
    check("rst_ovf", 64'(ovf_cnt), 64'd0);
    check("rst_wr_len", 64'(wr_len), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    init_done = 1'b1;

    // Single write burst
    push(1, 0);
    in_cnt = 12'(BL);
    wait_reqs(1);
    in_cnt = '0;
    wait_quiet();
    check("single_fill", 64'(ring_fill), 64'd32);
    check("in_rd_pulses", 64'(rd_pulses), 64'd32);

    // Contention alternation, wrapping both pointers
    push(0, 0); push(1, 256); push(0, 256); push(1, 0);
    push(0, 0); push(1, 256); push(0, 256);
    in_cnt = 12'(BL); out_free = 12'(BL);
    wait_reqs(8);
    in_cnt = '0; out_free = '0;
    wait_quiet();
    check("wrap_fill", 64'(ring_fill), 64'd0);

    // Fill the ring, then stall with input FIFO full
    push(1, 0); push(1, 256);
    in_cnt = 12'(BL);
    wait_reqs(10);
    in_cnt = '0;
    wait_quiet();
    check("full_fill", 64'(ring_fill), 64'd64);
    in_cnt = 12'(BL); in_full = 1'b1;
    repeat (10) tick();
    in_full = 1'b0; in_cnt = '0;
    repeat (2) tick();
    check("ovf_count", 64'(ovf_cnt), 64'd10);
    check("full_fill_held", 64'(ring_fill), 64'd64);
    check("full_idle", 64'(sched_idle), 64'd1);

    // Init loss during a write burst
    push(0, 0);
    out_free = 12'(BL);
    wait_reqs(11);
    out_free = '0;
    wait_quiet();
    check("pre_init_fill", 64'(ring_fill), 64'd32);
    ctrl_en = 1'b0;
    push(1, 0);
    in_cnt = 12'(BL);
    wait_reqs(12);
    repeat (3) tick();
    init_done = 1'b0;
    repeat (2) tick();
    check("init_loss_idle", 64'(sched_idle), 64'd1);
    check("init_loss_fill", 64'(ring_fill), 64'd32);
    push(1, 0);
    ctrl_en = 1'b1;
    init_done = 1'b1;
    wait_reqs(13);
    in_cnt = '0;
    wait_quiet();
    check("reissue_fill", 64'(ring_fill), 64'd64);

    // Flush with pointers apart, then read withheld until a new write lands
    push(0, 256);
    out_free = 12'(BL);
    wait_reqs(14);
    out_free = '0;
    wait_quiet();
    check("pre_flush_fill", 64'(ring_fill), 64'd32);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (3) tick();
    check("flush_fill", 64'(ring_fill), 64'd0);
    out_free = 12'(BL);
    repeat (10) tick();
    check("flush_no_read", 64'(req_seen), 64'd14);
    push(1, 256); push(0, 256);
    in_cnt = 12'(BL);
    wait_reqs(15);
    in_cnt = '0;
    wait_reqs(16);
    out_free = '0;
    wait_quiet();
    check("final_fill", 64'(ring_fill), 64'd0);
    check("final_ovf", 64'(ovf_cnt), 64'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
